// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Holds the arbiter state encoding, master index constants and the
// transaction length constants also used by the CPU bus interface.
package bus_arbiter_pkg;

    // Arbiter phases: idle/arbitrate, request handshake, write beats, read beats.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    // Master indices as seen on the grant vector.
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    // Transaction lengths in beats, shared with the CPU bus interface.
    localparam logic [2:0] LEN_SINGLE = 3'd1;
    localparam logic [2:0] LEN_LINE   = 3'd4;

    // A zero length field still moves one beat.
    function automatic logic [2:0] beats_of(input logic [2:0] len);
        return (len == 3'd0) ? LEN_SINGLE : len;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory bus between the CPU (m0) and DMA/video (m1) masters.
// Latency: one arbitration cycle before s_req_valid; request and data beats then pass through combinationally.
// Backpressure: the loser's request is held off with ready=0; the winner keeps the bus until its last beat.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int FIRST_GNT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [2:0]  m0_req_len,
    input  logic [3:0]  m0_req_mask,
    input  logic [31:0] m0_req_addr,
    input  logic        m0_req_we,
    input  logic        m0_write_valid,
    input  logic [31:0] m0_write_data,
    output logic        m0_read_valid,
    output logic [31:0] m0_read_data,
    input  logic        m0_read_ack,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [2:0]  m1_req_len,
    input  logic [3:0]  m1_req_mask,
    input  logic [31:0] m1_req_addr,
    input  logic        m1_req_we,
    input  logic        m1_write_valid,
    input  logic [31:0] m1_write_data,
    output logic        m1_read_valid,
    output logic [31:0] m1_read_data,
    input  logic        m1_read_ack,

    output logic        s_req_valid,
    input  logic        s_req_ready,
    output logic [2:0]  s_req_len,
    output logic [3:0]  s_req_mask,
    output logic [31:0] s_req_addr,
    output logic        s_req_we,
    output logic        s_write_valid,
    output logic [31:0] s_write_data,
    input  logic        s_read_valid,
    input  logic [31:0] s_read_data,
    output logic        s_read_ack,

    output logic [1:0]  gnt,
    output logic        proto_err
);

    // After reset the "previous winner" is the other master, so FIRST_GNT wins the first contest.
    localparam logic FIRST_IDX = (FIRST_GNT != 0) ? M_DMA : M_CPU;

    arb_state_t  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        we_q, we_d;
    logic        proto_err_q, proto_err_d;

    // Fields of whichever master currently holds the grant (all zero when idle).
    logic        sel_req_valid;
    logic [2:0]  sel_req_len;
    logic [3:0]  sel_req_mask;
    logic [31:0] sel_req_addr;
    logic        sel_req_we;
    logic        sel_write_valid;
    logic [31:0] sel_write_data;
    logic        sel_read_ack;

    logic        wr_phase;
    logic        rd_phase;
    logic        wr_fwd;
    logic        ack_fwd;
    logic        viol;

    // Returns the index of the master to grant; a contested pick alternates away from the last winner.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        logic pick;
        if (v0 && v1) begin
            pick = ~last;
        end else begin
            pick = (v1 && !v0) ? M_DMA : M_CPU;
        end
        return pick;
    endfunction

    // State register: arbiter phase, grant, beat counter, round-robin history and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            cnt_q       <= 3'd0;
            last_gnt_q  <= ~FIRST_IDX;
            we_q        <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, load the beat count on handshake, count beats down to release.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        proto_err_d = proto_err_q | viol;

        case (state_q)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    gnt_d   = (rr_pick(m0_req_valid, m1_req_valid, last_gnt_q) == M_DMA) ? 2'b10 : 2'b01;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_req_valid && s_req_ready) begin
                    cnt_d   = beats_of(sel_req_len);
                    we_d    = sel_req_we;
                    state_d = sel_req_we ? WDATA : RDATA;
                end
            end
            WDATA, RDATA: begin
                // A beat is a forwarded write strobe or a forwarded read ack, depending on the phase.
                if (wr_fwd || ack_fwd) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end
                    if (cnt_q == 3'd1) begin
                        state_d    = IDLE;
                        last_gnt_d = gnt_q[1];
                        gnt_d      = 2'b00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Output logic: mux the granted master onto the downstream bus and police stray strobes.
    always_comb begin
        sel_req_valid   = 1'b0;
        sel_req_len     = 3'd0;
        sel_req_mask    = 4'd0;
        sel_req_addr    = 32'd0;
        sel_req_we      = 1'b0;
        sel_write_valid = 1'b0;
        sel_write_data  = 32'd0;
        sel_read_ack    = 1'b0;

        case (gnt_q)
            2'b01: begin
                sel_req_valid   = m0_req_valid;
                sel_req_len     = m0_req_len;
                sel_req_mask    = m0_req_mask;
                sel_req_addr    = m0_req_addr;
                sel_req_we      = m0_req_we;
                sel_write_valid = m0_write_valid;
                sel_write_data  = m0_write_data;
                sel_read_ack    = m0_read_ack;
            end
            2'b10: begin
                sel_req_valid   = m1_req_valid;
                sel_req_len     = m1_req_len;
                sel_req_mask    = m1_req_mask;
                sel_req_addr    = m1_req_addr;
                sel_req_we      = m1_req_we;
                sel_write_valid = m1_write_valid;
                sel_write_data  = m1_write_data;
                sel_read_ack    = m1_read_ack;
            end
            default: begin
            end
        endcase

        wr_phase = (state_q == WDATA) && we_q;
        rd_phase = (state_q == RDATA) && !we_q;

        // Only strobes from the granted master in the matching phase reach the slave.
        wr_fwd  = wr_phase && sel_write_valid;
        ack_fwd = rd_phase && sel_read_ack;

        // Any strobe from a master without the grant, or in the wrong phase, is an error and is dropped.
        viol = (m0_write_valid && !gnt_q[0]) || (m1_write_valid && !gnt_q[1]) ||
               (m0_read_ack    && !gnt_q[0]) || (m1_read_ack    && !gnt_q[1]) ||
               (sel_write_valid && !wr_phase) || (sel_read_ack && !rd_phase);

        s_req_valid   = (state_q == REQ) && sel_req_valid;
        s_req_len     = sel_req_len;
        s_req_mask    = sel_req_mask;
        s_req_addr    = sel_req_addr;
        s_req_we      = sel_req_we;
        m0_req_ready  = (state_q == REQ) && gnt_q[0] && s_req_ready;
        m1_req_ready  = (state_q == REQ) && gnt_q[1] && s_req_ready;

        s_write_valid = wr_fwd;
        s_write_data  = sel_write_data;

        m0_read_valid = rd_phase && gnt_q[0] && s_read_valid;
        m1_read_valid = rd_phase && gnt_q[1] && s_read_valid;
        // Read data is broadcast; it is forced low while reset is held so every output reads zero.
        m0_read_data  = rst_i ? 32'd0 : s_read_data;
        m1_read_data  = rst_i ? 32'd0 : s_read_data;
        s_read_ack    = ack_fwd;

        gnt           = gnt_q;
        proto_err     = proto_err_q;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single downstream memory request/data bus between two masters that use the CPU-bus request protocol.
- Master 0 is the CPU bus interface; master 1 is a DMA/video fetch engine.
- The master picked by round-robin arbitration holds the grant for its whole transaction: request handshake plus all data beats.
- Sits between the masters and the memory/peripheral interconnect.

Parameters:
- FIRST_GNT, 0, master that wins the first contested arbitration after reset.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- mN_req_valid  in  1  request valid, master N (N=0,1); held until ready
- mN_req_ready  out  1  request accepted, master N
- mN_req_len  in  3  beats in transaction
- mN_req_mask  in  4  byte enables
- mN_req_addr  in  32  address
- mN_req_we  in  1  1=write
- mN_write_valid  in  1  write beat strobe (1-cycle pulse)
- mN_write_data  in  32  write beat data
- mN_read_valid  out  1  read beat available to master N
- mN_read_data  out  32  read beat data
- mN_read_ack  in  1  read beat consumed (1-cycle pulse)
- s_req_valid / s_req_ready / s_req_len / s_req_mask / s_req_addr / s_req_we  out/in/out/out/out/out  1/1/3/4/32/1  downstream request
- s_write_valid / s_write_data  out  1/32  downstream write beat
- s_read_valid / s_read_data / s_read_ack  in/in/out  1/32/1  downstream read beat
- gnt  out  2  one-hot current grant; 00 when idle
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: async. state=IDLE, gnt=00, beat counter=0, last_gnt=~FIRST_GNT, proto_err=0. All valid/ready/ack outputs 0, data outputs 0.
- Mid-transaction reset: immediate abort to IDLE. Nothing is replayed.
- State IDLE:
  - If any mN_req_valid: latch grant, go to REQ.
  - Both valid: grant the master != last_gnt. One valid: grant it.
  - Arbitration costs one cycle. s_req_valid rises the cycle after mN_req_valid is first sampled.
- State REQ:
  - s_req_* are combinationally muxed from the granted master.
  - mN_req_ready = s_req_ready for the granted master, 0 for the other.
  - On s_req_valid & s_req_ready:
    - load counter = req_len, with 0 treated as 1.
    - latch we.
    - go to WDATA if we=1, else RDATA.
- State WDATA:
  - s_write_valid/data forwarded from the granted master.
  - Each strobe decrements the counter.
  - Strobe with counter==1: go to IDLE, last_gnt <= granted, gnt <= 00.
- State RDATA:
  - s_read_valid routed only to the granted master; the other sees 0.
  - mN_read_data = s_read_data broadcast to both masters.
  - s_read_ack = granted master's read_ack.
  - Each ack decrements the counter. Ack with counter==1: return to IDLE as in WDATA.
- Re-arbitration: a request pending on the final-beat cycle is arbitrated in the following IDLE cycle (one-cycle bubble). Back-to-back contested traffic alternates strictly.
- Non-granted request: mN_req_valid is simply held off (ready=0). Not an error.
- proto_err set (never cleared except by reset) when any of:
  - the non-granted master pulses write_valid or read_ack;
  - the granted master pulses write_valid outside WDATA;
  - the granted master pulses read_ack outside RDATA.
- Offending strobes are dropped, not forwarded.
- Counter width is 3 bits and never underflows; it decrements only while nonzero.

Decomposition:
- Shared package holds:
  - state encoding IDLE/REQ/WDATA/RDATA;
  - master index constants M_CPU=0, M_DMA=1;
  - SIZ/len constants LEN_SINGLE=1, LEN_LINE=4, shared with the CPU bus interface.
- No sub-module; the arbiter fits in a single module. The round-robin pick is a local function.

Test Plan:
- Single write: m0 req len=1 addr=0x00001000 mask=1111, one write_valid with data 0xDEADBEEF. Expect s_write_data=0xDEADBEEF, gnt 01→00, m1 sees ready=0 throughout.
- Line read: m1 req len=4, slave supplies 4 beats 0x11..0x44 with acks. Expect m1_read_valid pulses 4 times, m0_read_valid stays 0, return to IDLE after the 4th ack.
- Contention: m0 and m1 both request in the same cycle, repeated 4 times. Expect grant order m0,m1,m0,m1 with FIRST_GNT=0.
- len=0 request from m0 (read): exactly one beat completes the transaction.
- Violation: m1 pulses write_valid while m0 holds the grant. Expect proto_err=1, s_write_valid not asserted, m0 transaction unaffected.
- Reset asserted during RDATA beat 2 of 4: all outputs 0 immediately. After release, a new m1 request is granted normally.
